trigger_multi: RTL and testbench
================================

Name: trigger_multi

Overview:
- Parametrised successor to the single-channel edge trigger.
- Selects one of CHANNELS sample streams and detects rising, falling or either-edge crossings, with hysteresis bounds.
- Adds a programmable post-arm holdoff and reports which edge fired.
- Sits between the ADC capture front-end and the sampler. The sampler consumes `trigger` and re-arms via `trig_rst`.

Parameters:
- WIDTH, 8, sample and bound width in bits.
- CHANNELS, 2, number of input channels (≥1).
- HOLD_W, 16, holdoff counter width.
- TOUT_W, 24, auto-timeout counter width (used only with TRIG_AUTO_EN).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- trig_rst  in  1  synchronous re-arm request from sampler.
- en  in  1  trigger enable; low forces IDLE.
- data  in  CHANNELS*WIDTH  packed samples; channel k at [k*WIDTH +: WIDTH].
- ch_sel  in  $clog2(CHANNELS) (min 1)  source channel.
- mode  in  2  00 off, 01 rise, 10 fall, 11 either.
- upper_bound  in  WIDTH  upper hysteresis threshold.
- lower_bound  in  WIDTH  lower hysteresis threshold.
- holdoff  in  HOLD_W  cycles to ignore crossings after arming.
- auto_timeout  in  TOUT_W  auto-fire limit; ignored without TRIG_AUTO_EN.
- trigger  out  1  sticky trigger level.
- trig_pulse  out  1  one-cycle strobe on fire.
- trig_rising  out  1  1 = rising edge caused the fire, 0 = falling.
- armed  out  1  high in ARMED state.
- trig_auto  out  1  fire came from timeout (constant 0 without macro).

Behaviour:
- Reset: state IDLE; all flags, counters and outputs 0.
- All comparisons are unsigned and strict. Bounds are used as given; no swap. Equal bounds disable hysteresis.
- Channel mux is combinational. Every output is registered: a qualifying sample at edge N is reflected in outputs after edge N (1-cycle latency).
- States:
  - IDLE: `en && mode!=0` → HOLDOFF; counter ← holdoff; lo/hi flags cleared.
  - HOLDOFF: counter decrements each cycle. Flags are tracked but cannot fire. Counter==0 → ARMED. holdoff=0 gives one HOLDOFF cycle.
  - ARMED: hysteresis tracking.
    - data < lower_bound → lo=1, hi=0.
    - data > upper_bound → hi=1, lo=0.
    - Rise fires when lo && data > upper_bound && mode[0].
    - Fall fires when hi && data < lower_bound && mode[1].
    - On fire → FIRED; trigger=1; trig_pulse=1 for one cycle; trig_rising latched.
  - FIRED: outputs hold. Further crossings are ignored.
- trig_rst: in any state except IDLE → HOLDOFF; counter reloaded; flags, trigger and trig_rising cleared. It has priority over a same-cycle fire, so no pulse is issued.
- en low: → IDLE next cycle; trigger and flags cleared.
- mode written to 00 while not IDLE: → IDLE next cycle.
- ch_sel change while HOLDOFF/ARMED: flags cleared that cycle; no fire that cycle.
- Bound, mode or holdoff changes while ARMED: take effect on the next compare. Counter is not reloaded.
- armed = (state==ARMED). trig_pulse never asserts in two consecutive cycles.
- rst asserted mid-operation: immediate return to reset values, independent of clk.

Optional Feature:
- Macro TRIG_AUTO_EN.
- Defined:
  - Timeout counter clears on entry to ARMED and increments each ARMED cycle.
  - When it reaches auto_timeout (≠0) with no edge: fire with trig_auto=1 and trig_rising=0.
  - auto_timeout=0 disables auto-fire.
  - A real edge in the same cycle as timeout wins (trig_auto=0).
  - trig_auto clears with trigger.
- Undefined: no timeout counter; trig_auto tied 0; auto_timeout unused.

Decomposition:
- Package trigger_pkg: trig_mode_e (OFF, RISE, FALL, EITHER), trig_state_e (IDLE, HOLDOFF, ARMED, FIRED).
- Sub-module trig_hyst: per-sample lo/hi flag tracker and rise/fall fire-condition logic, with a clear input. One instance follows the channel mux.

Test Plan:
1. CHANNELS=2, ch_sel=1, mode=01, bounds 100/50, holdoff=0; ch1 ramps 40→120 → trig_pulse one cycle after the sample of 120; trig_rising=1; trigger stays high.
2. mode=10, bounds 100/50, ch0 60→110→90→45 → no fire at 90; fire at 45 with trig_rising=0. Then 55→30 → no second pulse.
3. holdoff=10; edge 5 cycles after arm → ignored. Repeat with edge 12 cycles after arm → fires.
4. Edge and trig_rst in the same cycle → no trig_pulse; state HOLDOFF; trigger=0.
5. mode=11, bounds 100/50, ch_sel toggled mid-ARMED while ch0=30, ch1=200 → flags cleared; no fire until a fresh crossing on the selected channel.
6. TRIG_AUTO_EN, auto_timeout=20, flat data=75 → fire on ARMED cycle 20 with trig_auto=1. rst mid-count → all outputs 0 asynchronously.

Source files
------------

// File: rtl/trigger_pkg.sv
// Shared types for the multi-channel edge trigger.
package trigger_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'b00,
        RISE   = 2'b01,
        FALL   = 2'b10,
        EITHER = 2'b11
    } trig_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        HOLDOFF,
        ARMED,
        FIRED
    } trig_state_e;

    function automatic int sel_width(input int ch);
        return (ch > 1) ? $clog2(ch) : 1;
    endfunction

endpackage

// File: rtl/trig_hyst.sv
// Hysteresis tracker: remembers last excursion below/above the bounds
// and flags a rise or fall crossing on the current sample.
module trig_hyst #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             track,
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] upper_bound,
    input  logic [WIDTH-1:0] lower_bound,
    output logic             rise_hit,
    output logic             fall_hit
);

    logic lo_q, lo_d;
    logic hi_q, hi_d;
    logic below, above;

    assign below = sample < lower_bound;
    assign above = sample > upper_bound;

    always_comb begin
        lo_d = lo_q;
        hi_d = hi_q;
        if (clear) begin
            lo_d = 1'b0;
            hi_d = 1'b0;
        end else if (track) begin
            if (below) begin
                lo_d = 1'b1;
                hi_d = 1'b0;
            end else if (above) begin
                hi_d = 1'b1;
                lo_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_q <= 1'b0;
            hi_q <= 1'b0;
        end else begin
            lo_q <= lo_d;
            hi_q <= hi_d;
        end
    end

    // Fire conditions use the flags from before this sample.
    assign rise_hit = lo_q && above;
    assign fall_hit = hi_q && below;

endmodule

// File: rtl/trigger_multi.sv
// Multi-channel hysteresis edge trigger with post-arm holdoff.
// Define TRIG_AUTO_EN to add the auto-fire timeout.
module trigger_multi
    import trigger_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int HOLD_W   = 16,
    parameter int TOUT_W   = 24
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                trig_rst,
    input  logic                                en,
    input  logic [CHANNELS*WIDTH-1:0]           data,
    input  logic [sel_width(CHANNELS)-1:0]      ch_sel,
    input  logic [1:0]                          mode,
    input  logic [WIDTH-1:0]                    upper_bound,
    input  logic [WIDTH-1:0]                    lower_bound,
    input  logic [HOLD_W-1:0]                   holdoff,
    input  logic [TOUT_W-1:0]                   auto_timeout,
    output logic                                trigger,
    output logic                                trig_pulse,
    output logic                                trig_rising,
    output logic                                armed,
    output logic                                trig_auto
);

    localparam int SEL_W = sel_width(CHANNELS);

    trig_state_e       state_q, state_d;
    logic [HOLD_W-1:0] cnt_q, cnt_d;
    logic              trigger_q, trigger_d;
    logic              pulse_q, pulse_d;
    logic              rising_q, rising_d;
    logic              auto_q, auto_d;
    logic [SEL_W-1:0]  ch_sel_q;

    logic [WIDTH-1:0]  sample;
    logic              flag_clr, track;
    logic              rise_hit, fall_hit;
    logic              sel_chg;

`ifdef TRIG_AUTO_EN
    logic [TOUT_W-1:0] tout_q, tout_d;
    logic              tout_hit;
    assign tout_hit = (auto_timeout != '0) &&
                      (tout_q + 1'b1 == auto_timeout);
`else
    logic unused_tout;
    assign unused_tout = ^auto_timeout;
`endif

    always_comb begin
        sample = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (ch_sel == SEL_W'(k)) sample = data[k*WIDTH +: WIDTH];
        end
    end

    assign sel_chg = ch_sel != ch_sel_q;

    trig_hyst #(.WIDTH(WIDTH)) u_hyst (
        .clk         (clk),
        .rst         (rst),
        .clear       (flag_clr),
        .track       (track),
        .sample      (sample),
        .upper_bound (upper_bound),
        .lower_bound (lower_bound),
        .rise_hit    (rise_hit),
        .fall_hit    (fall_hit)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        trigger_d = trigger_q;
        pulse_d   = 1'b0;
        rising_d  = rising_q;
        auto_d    = auto_q;
        flag_clr  = 1'b0;
        track     = 1'b0;
`ifdef TRIG_AUTO_EN
        tout_d    = tout_q;
`endif
        if (!en || (state_q != IDLE && mode == OFF)) begin
            state_d   = IDLE;
            cnt_d     = '0;
            trigger_d = 1'b0;
            rising_d  = 1'b0;
            auto_d    = 1'b0;
            flag_clr  = 1'b1;
        end else if (state_q != IDLE && trig_rst) begin
            // Re-arm beats a same-cycle fire: no pulse issued.
            state_d   = HOLDOFF;
            cnt_d     = holdoff;
            trigger_d = 1'b0;
            rising_d  = 1'b0;
            auto_d    = 1'b0;
            flag_clr  = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    flag_clr = 1'b1;
                    if (mode != OFF) begin
                        state_d = HOLDOFF;
                        cnt_d   = holdoff;
                    end
                end
                HOLDOFF: begin
                    flag_clr = sel_chg;
                    track    = !sel_chg;
                    if (cnt_q == '0) begin
                        state_d = ARMED;
`ifdef TRIG_AUTO_EN
                        tout_d  = '0;
`endif
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ARMED: begin
                    flag_clr = sel_chg;
                    track    = !sel_chg;
`ifdef TRIG_AUTO_EN
                    tout_d   = tout_q + 1'b1;
`endif
                    if (!sel_chg) begin
                        if (rise_hit && mode[0]) begin
                            state_d   = FIRED;
                            trigger_d = 1'b1;
                            pulse_d   = 1'b1;
                            rising_d  = 1'b1;
                            auto_d    = 1'b0;
                        end else if (fall_hit && mode[1]) begin
                            state_d   = FIRED;
                            trigger_d = 1'b1;
                            pulse_d   = 1'b1;
                            rising_d  = 1'b0;
                            auto_d    = 1'b0;
                        end
`ifdef TRIG_AUTO_EN
                        else if (tout_hit) begin
                            state_d   = FIRED;
                            trigger_d = 1'b1;
                            pulse_d   = 1'b1;
                            rising_d  = 1'b0;
                            auto_d    = 1'b1;
                        end
`endif
                    end
                end
                FIRED: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            trigger_q <= 1'b0;
            pulse_q   <= 1'b0;
            rising_q  <= 1'b0;
            auto_q    <= 1'b0;
            ch_sel_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            trigger_q <= trigger_d;
            pulse_q   <= pulse_d;
            rising_q  <= rising_d;
            auto_q    <= auto_d;
            ch_sel_q  <= ch_sel;
        end
    end

`ifdef TRIG_AUTO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tout_q <= '0;
        else     tout_q <= tout_d;
    end
`endif

    assign trigger     = trigger_q;
    assign trig_pulse  = pulse_q;
    assign trig_rising = rising_q;
    assign armed       = state_q == ARMED;
    assign trig_auto   = auto_q;

endmodule

// File: tb/tb_trigger_multi.sv
// Directed vector bench for trigger_multi (2 channels, 8-bit samples).
module tb_trigger_multi;

    logic        clk;
    logic        rst;
    logic        trig_rst;
    logic        en;
    logic [15:0] data;
    logic [0:0]  ch_sel;
    logic [1:0]  mode;
    logic [7:0]  upper_bound;
    logic [7:0]  lower_bound;
    logic [15:0] holdoff;
    logic [23:0] auto_timeout;
    logic        trigger;
    logic        trig_pulse;
    logic        trig_rising;
    logic        armed;
    logic        trig_auto;

    int n_vec = 0;
    int n_err = 0;

    trigger_multi #(
        .WIDTH(8), .CHANNELS(2), .HOLD_W(16), .TOUT_W(24)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .trig_rst     (trig_rst),
        .en           (en),
        .data         (data),
        .ch_sel       (ch_sel),
        .mode         (mode),
        .upper_bound  (upper_bound),
        .lower_bound  (lower_bound),
        .holdoff      (holdoff),
        .auto_timeout (auto_timeout),
        .trigger      (trigger),
        .trig_pulse   (trig_pulse),
        .trig_rising  (trig_rising),
        .armed        (armed),
        .trig_auto    (trig_auto)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected bits: {trigger, trig_pulse, trig_rising, armed, trig_auto}
    typedef struct {
        logic       en;
        logic [1:0] mode;
        logic       sel;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[24];

    function automatic vec_t mk(input logic e, input logic [1:0] m,
                                input logic s, input logic [7:0] a,
                                input logic [7:0] b, input logic [3:0] x);
        vec_t v;
        v.en   = e;
        v.mode = m;
        v.sel  = s;
        v.d0   = a;
        v.d1   = b;
        v.exp  = {x, 1'b0};
        return v;
    endfunction

    task automatic check(input string nm, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {trigger, trig_pulse, trig_rising, armed, trig_auto};
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %b want %b (trig,pulse,rise,armed,auto)",
                     nm, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rise on ch1
        tbl[0]  = mk(1, 2'b01, 1, 0,   40,  4'b0000);
        tbl[1]  = mk(1, 2'b01, 1, 0,   40,  4'b0001);
        tbl[2]  = mk(1, 2'b01, 1, 0,   60,  4'b0001);
        tbl[3]  = mk(1, 2'b01, 1, 0,   80,  4'b0001);
        tbl[4]  = mk(1, 2'b01, 1, 0,   100, 4'b0001);
        tbl[5]  = mk(1, 2'b01, 1, 0,   120, 4'b1110);
        tbl[6]  = mk(1, 2'b01, 1, 0,   120, 4'b1010);
        tbl[7]  = mk(1, 2'b01, 1, 0,   40,  4'b1010);
        // fall on ch0
        tbl[8]  = mk(0, 2'b10, 0, 60,  0,   4'b0000);
        tbl[9]  = mk(1, 2'b10, 0, 60,  0,   4'b0000);
        tbl[10] = mk(1, 2'b10, 0, 60,  0,   4'b0001);
        tbl[11] = mk(1, 2'b10, 0, 110, 0,   4'b0001);
        tbl[12] = mk(1, 2'b10, 0, 90,  0,   4'b0001);
        tbl[13] = mk(1, 2'b10, 0, 45,  0,   4'b1100);
        tbl[14] = mk(1, 2'b10, 0, 55,  0,   4'b1000);
        tbl[15] = mk(1, 2'b10, 0, 30,  0,   4'b1000);
        // mode off, then channel switch in either mode
        tbl[16] = mk(1, 2'b00, 0, 30,  200, 4'b0000);
        tbl[17] = mk(1, 2'b11, 0, 30,  200, 4'b0000);
        tbl[18] = mk(1, 2'b11, 0, 30,  200, 4'b0001);
        tbl[19] = mk(1, 2'b11, 0, 30,  200, 4'b0001);
        tbl[20] = mk(1, 2'b11, 1, 30,  200, 4'b0001);
        tbl[21] = mk(1, 2'b11, 1, 30,  200, 4'b0001);
        tbl[22] = mk(1, 2'b11, 1, 30,  200, 4'b0001);
        tbl[23] = mk(1, 2'b11, 1, 30,  30,  4'b1100);

        rst          = 1'b1;
        trig_rst     = 1'b0;
        en           = 1'b0;
        data         = '0;
        ch_sel       = '0;
        mode         = 2'b00;
        upper_bound  = 8'd100;
        lower_bound  = 8'd50;
        holdoff      = 16'd0;
        auto_timeout = 24'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 5'b00000);
        rst = 1'b0;

        for (int i = 0; i < 24; i++) begin
            en     = tbl[i].en;
            mode   = tbl[i].mode;
            ch_sel = tbl[i].sel;
            data   = {tbl[i].d1, tbl[i].d0};
            tick();
            check($sformatf("vec%0d", i), tbl[i].exp);
        end

        // holdoff of 10: edge inside holdoff ignored, later edge fires
        en = 1'b0;
        tick();
        check("hold_idle", 5'b00000);
        holdoff = 16'd10;
        mode    = 2'b01;
        ch_sel  = 1'b0;
        data    = {8'd0, 8'd30};
        en      = 1'b1;
        tick();
        check("hold_enter", 5'b00000);
        for (int i = 1; i <= 12; i++) begin
            data[7:0] = (i == 5 || i == 12) ? 8'd120 : 8'd30;
            tick();
            check($sformatf("hold%0d", i),
                  (i == 12) ? 5'b11100 : (i == 11) ? 5'b00010 : 5'b00000);
        end

        // re-arm, then re-arm colliding with a rising edge
        holdoff  = 16'd0;
        trig_rst = 1'b1;
        tick();
        check("rearm", 5'b00000);
        trig_rst  = 1'b0;
        data[7:0] = 8'd30;
        tick();
        check("rearm_armed", 5'b00010);
        data[7:0] = 8'd120;
        trig_rst  = 1'b1;
        tick();
        check("rst_vs_edge", 5'b00000);
        trig_rst = 1'b0;
        tick();
        check("rst_vs_edge_armed", 5'b00010);
        tick();
        check("no_rise_from_hi", 5'b00010);
        mode      = 2'b11;
        data[7:0] = 8'd30;
        tick();
        check("mode_chg_fall", 5'b11000);
        tick();
        check("pulse_single", 5'b10000);

        // asynchronous reset between clock edges
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", 5'b00000);
        @(negedge clk);
        rst = 1'b0;

`ifdef TRIG_AUTO_EN
        auto_timeout = 24'd20;
        mode         = 2'b01;
        data         = {8'd0, 8'd75};
        en           = 1'b1;
        tick();
        check("auto_hold", 5'b00000);
        tick();
        check("auto_arm", 5'b00010);
        for (int i = 1; i <= 20; i++) begin
            tick();
            check($sformatf("auto%0d", i),
                  (i == 20) ? 5'b11001 : 5'b00010);
        end
        trig_rst = 1'b1;
        tick();
        check("auto_clear", 5'b00000);
        trig_rst = 1'b0;
        repeat (6) tick();
        check("auto_count", 5'b00010);
        #2;
        rst = 1'b1;
        #1;
        check("auto_async_rst", 5'b00000);
        @(negedge clk);
        rst = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
